safe_solver: RTL and testbench

Automatic codebreaker for the 4-digit safe game: plays the guessing side of the guess/feedback exchange against the code-holding judge. The judge holds the LFSR code and scores guesses. On `start` the block issues guesses. It absorbs each correct/misplaced score and keeps the score history. It searches the 256-code space for the next code consistent with every score so far. It stops on a solve, on an exhausted try budget, or when the feedback is contradictory. It sits where the key-driven guess entry sits and is used for self-test and demo mode.

---
 rtl/safe_pkg.sv | 30 +++
 rtl/safe_score.sv | 44 ++++
 rtl/safe_solver.sv | 197 +++++++++++++++++++
 tb/tb_safe_solver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/safe_pkg.sv
// Shared types for the safe game solver and judge: code, score and history entry.
// No logic, so no latency.
// No flow control.
package safe_pkg;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 2;
    localparam int CODE_W  = DIGITS * DIGIT_W;

    typedef logic [CODE_W-1:0] code_t;

    typedef struct packed {
        logic [3:0] correct;
        logic [3:0] misplaced;
    } score_t;

    typedef struct packed {
        code_t  code;
        score_t score;
    } hist_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        ISSUE,
        WAIT_FB,
        DONE
    } state_t;

endpackage

// File: rtl/safe_score.sv
// Scores code a against code b: right digit in the right place, and right digit in the wrong place.
// Purely combinational, so zero latency.
// No flow control. The judge can reuse this block so both ends score identically.
// Ports: a, b = codes being compared; score = {correct, misplaced}.
module safe_score
    import safe_pkg::*;
(
    input  code_t  a,
    input  code_t  b,
    output score_t score
);

    logic [3:0] correct;
    logic [3:0] common;
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;

    always_comb begin
        correct = '0;
        common  = '0;
        cnt_a   = '0;
        cnt_b   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (a[k*DIGIT_W +: DIGIT_W] == b[k*DIGIT_W +: DIGIT_W]) begin
                correct = correct + 4'd1;
            end
        end
        // For each digit value, the digits the two codes share is the smaller of
        // the two occurrence counts. Summed over all values, this counts every
        // value match, whether or not the positions agree.
        for (int v = 0; v < (1 << DIGIT_W); v++) begin
            cnt_a = '0;
            cnt_b = '0;
            for (int k = 0; k < DIGITS; k++) begin
                cnt_a = cnt_a + {2'b00, (a[k*DIGIT_W +: DIGIT_W] == DIGIT_W'(v))};
                cnt_b = cnt_b + {2'b00, (b[k*DIGIT_W +: DIGIT_W] == DIGIT_W'(v))};
            end
            common = common + {1'b0, ((cnt_a < cnt_b) ? cnt_a : cnt_b)};
        end
        score.correct   = correct;
        score.misplaced = common - correct;
    end

endmodule

// File: rtl/safe_solver.sv
// Codebreaker for the 4-digit safe game. It issues guesses that are consistent with every score received so far.
// Latency: the first guess is offered 2 cycles after start. Each later candidate costs 1..hist_cnt search cycles.
// Backpressure: guess is held stable until guess_ack. Feedback is accepted only in WAIT_FB.
// Macro SAFE_SOLVER_PRUNE_EN enables history storage and the consistency search.
// Without it, guesses simply step 0x00, 0x01, ... and feedback only detects a solve.
// Ports: start / guess_valid / guess / guess_ack / fb_valid / fb_correct / fb_misplaced carry the judge exchange.
// busy / done / solved / fail / tries report the game status. clk is the clock; reset is synchronous and active-high.
module safe_solver #(
    parameter int MAX_TRIES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       guess_valid,
    output logic [7:0] guess,
    input  logic       guess_ack,
    input  logic       fb_valid,
    input  logic [3:0] fb_correct,
    input  logic [3:0] fb_misplaced,
    output logic       busy,
    output logic       done,
    output logic       solved,
    output logic       fail,
    output logic [4:0] tries
);
    import safe_pkg::*;

    state_t     state_q, state_d;
    code_t      cand_q, cand_d;
    code_t      guess_q, guess_d;
    logic       guess_valid_q, guess_valid_d;
    logic [4:0] tries_q, tries_d;
    logic       solved_q, solved_d;
    logic       fail_q, fail_d;
    logic       busy_q, done_q;
    logic       accept;

`ifdef SAFE_SOLVER_PRUNE_EN
    localparam int HIST_AW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    hist_entry_t hist [MAX_TRIES];
    hist_entry_t hist_rd;
    logic [4:0]  hist_cnt_q, hist_cnt_d;
    logic [4:0]  h_q, h_d;
    logic        hist_we;
    score_t      cand_score;
    score_t      fb_score;

    assign fb_score = '{correct: fb_correct, misplaced: fb_misplaced};
    assign hist_rd  = hist[h_q[HIST_AW-1:0]];

    safe_score u_score (
        .a     (cand_q),
        .b     (hist_rd.code),
        .score (cand_score)
    );

    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist[hist_cnt_q[HIST_AW-1:0]] <= '{code: guess_q, score: fb_score};
        end
    end
`else
    logic unused_misplaced;
    assign unused_misplaced = ^fb_misplaced;
`endif

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        guess_d       = guess_q;
        guess_valid_d = guess_valid_q;
        tries_d       = tries_q;
        solved_d      = solved_q;
        fail_d        = fail_q;
        accept        = 1'b0;
`ifdef SAFE_SOLVER_PRUNE_EN
        hist_cnt_d    = hist_cnt_q;
        h_d           = h_q;
        hist_we       = 1'b0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SEARCH;
                    cand_d   = '0;
                    tries_d  = '0;
                    solved_d = 1'b0;
                    fail_d   = 1'b0;
`ifdef SAFE_SOLVER_PRUNE_EN
                    hist_cnt_d = '0;
                    h_d        = '0;
`endif
                end
            end
            SEARCH: begin
`ifdef SAFE_SOLVER_PRUNE_EN
                // Walk the history one entry per cycle. Any mismatch moves to the
                // next candidate and restarts the walk from the first entry.
                if (hist_cnt_q == '0) begin
                    accept = 1'b1;
                end else if (cand_score != hist_rd.score) begin
                    if (cand_q == 8'hFF) begin
                        state_d = DONE;
                        fail_d  = 1'b1;
                    end else begin
                        cand_d = cand_q + 8'd1;
                        h_d    = '0;
                    end
                end else if (h_q == hist_cnt_q - 5'd1) begin
                    accept = 1'b1;
                end else begin
                    h_d = h_q + 5'd1;
                end
`else
                accept = 1'b1;
`endif
                if (accept) begin
                    guess_d       = cand_q;
                    guess_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (guess_ack) begin
                    guess_valid_d = 1'b0;
                    tries_d       = tries_q + 5'd1;
                    state_d       = WAIT_FB;
                end
            end
            WAIT_FB: begin
                if (fb_valid) begin
                    if (fb_correct == 4'd4) begin
                        state_d  = DONE;
                        solved_d = 1'b1;
                    end else begin
`ifdef SAFE_SOLVER_PRUNE_EN
                        hist_we    = 1'b1;
                        hist_cnt_d = hist_cnt_q + 5'd1;
                        h_d        = '0;
`endif
                        // Every code below this guess was already ruled out.
                        cand_d = guess_q + 8'd1;
                        if ((tries_q == 5'(MAX_TRIES)) || (guess_q == 8'hFF)) begin
                            state_d = DONE;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cand_q        <= '0;
            guess_q       <= '0;
            guess_valid_q <= 1'b0;
            tries_q       <= '0;
            solved_q      <= 1'b0;
            fail_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef SAFE_SOLVER_PRUNE_EN
            hist_cnt_q    <= '0;
            h_q           <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            guess_q       <= guess_d;
            guess_valid_q <= guess_valid_d;
            tries_q       <= tries_d;
            solved_q      <= solved_d;
            fail_q        <= fail_d;
            busy_q        <= (state_d == SEARCH) || (state_d == ISSUE) || (state_d == WAIT_FB);
            done_q        <= (state_d == DONE);
`ifdef SAFE_SOLVER_PRUNE_EN
            hist_cnt_q    <= hist_cnt_d;
            h_q           <= h_d;
`endif
        end
    end

    assign guess_valid = guess_valid_q;
    assign guess       = guess_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign solved      = solved_q;
    assign fail        = fail_q;
    assign tries       = tries_q;

endmodule

// File: tb/tb_safe_solver.sv
// Testbench for safe_solver: a behavioural judge and reference model check every guess and every game outcome.
// Outputs are sampled and inputs driven on the falling clock edge.
// Feedback and ack delays are randomised.
module tb_safe_solver;
    localparam int MAX_TRIES = 16;

    logic       clk = 1'b0;
    logic       reset, start, guess_ack, fb_valid;
    logic [3:0] fb_correct, fb_misplaced;
    logic       guess_valid, busy, done, solved, fail;
    logic [7:0] guess;
    logic [4:0] tries;

    int errors = 0;
    int checks = 0;
    int hist_g[$];
    int hist_s[$];

    always #5 clk = ~clk;

    safe_solver #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .guess_valid  (guess_valid),
        .guess        (guess),
        .guess_ack    (guess_ack),
        .fb_valid     (fb_valid),
        .fb_correct   (fb_correct),
        .fb_misplaced (fb_misplaced),
        .busy         (busy),
        .done         (done),
        .solved       (solved),
        .fail         (fail),
        .tries        (tries)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int digit(input int code, input int k);
        return (code / (4 ** k)) % 4;
    endfunction

    // Returns correct*16 + misplaced.
    function automatic int ref_score(input int a, input int b);
        int ca[4];
        int cb[4];
        int cor;
        int common;
        ca = '{default: 0};
        cb = '{default: 0};
        cor = 0;
        common = 0;
        for (int k = 0; k < 4; k++) begin
            if (digit(a, k) == digit(b, k)) cor++;
            ca[digit(a, k)]++;
            cb[digit(b, k)]++;
        end
        for (int v = 0; v < 4; v++) common += (ca[v] < cb[v]) ? ca[v] : cb[v];
        return cor * 16 + (common - cor);
    endfunction

    // Smallest code after `last` that agrees with every recorded score. Returns -1 if there is none.
    function automatic int next_guess(input int last);
`ifdef SAFE_SOLVER_PRUNE_EN
        bit ok;
        for (int c = last + 1; c < 256; c++) begin
            ok = 1'b1;
            foreach (hist_g[i]) if (ref_score(c, hist_g[i]) != hist_s[i]) ok = 1'b0;
            if (ok) return c;
        end
        return -1;
`else
        return (last < 255) ? last + 1 : -1;
`endif
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".guess_valid"}, guess_valid, 0);
        chk({tag, ".guess"}, guess, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".solved"}, solved, 0);
        chk({tag, ".fail"}, fail, 0);
        chk({tag, ".tries"}, tries, 0);
    endtask

    // Plays one game against a judge holding `secret`.
    // contra: reply 0 correct / 1 misplaced to every guess.
    // ack_hold: cycles to hold the ack low (<0 means random).
    // stray: inject a stray start and fb_valid while the guess waits for its ack.
    task automatic play(input int secret, input bit contra, input int ack_hold,
                        input bit stray, input string tag);
        int  exp_g, n, sc, wait_cyc, hold;
        bit  ended;
        hist_g.delete();
        hist_s.delete();
        n = 0;
        ended = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_n1"}, busy, 1);
        chk({tag, ".gv_n1"}, guess_valid, 0);
        exp_g = 0;
        while (!ended) begin
            wait_cyc = 0;
            while (!guess_valid && !done && wait_cyc < 5000) begin
                @(negedge clk);
                wait_cyc++;
            end
            if (!guess_valid && !done) begin
                chk({tag, ".timeout_done"}, done, 1);
                ended = 1'b1;
            end else if (exp_g < 0) begin
                chk({tag, ".exhaust_gv"}, guess_valid, 0);
                chk({tag, ".exhaust_fail"}, fail, 1);
                chk({tag, ".exhaust_solved"}, solved, 0);
                ended = 1'b1;
            end else begin
                if (n == 0) chk({tag, ".first_latency"}, wait_cyc, 1);
                chk({tag, ".gv"}, guess_valid, 1);
                chk({tag, ".guess"}, guess, exp_g);
                hold = (ack_hold >= 0) ? ack_hold : $urandom_range(0, 2);
                for (int i = 0; i < hold; i++) begin
                    if (stray && i == 0) start = 1'b1;
                    if (stray && i == 1) begin
                        fb_valid = 1'b1;
                        fb_correct = 4'd4;
                        fb_misplaced = 4'd0;
                    end
                    @(negedge clk);
                    start = 1'b0;
                    fb_valid = 1'b0;
                    chk({tag, ".hold_gv"}, guess_valid, 1);
                    chk({tag, ".hold_guess"}, guess, exp_g);
                end
                if (stray) chk({tag, ".stray_done"}, done, 0);
                guess_ack = 1'b1;
                @(negedge clk);
                guess_ack = 1'b0;
                n++;
                chk({tag, ".gv_drop"}, guess_valid, 0);
                chk({tag, ".tries"}, tries, n);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sc = contra ? 1 : ref_score(secret, exp_g);
                fb_valid = 1'b1;
                fb_correct = 4'(sc / 16);
                fb_misplaced = 4'(sc % 16);
                @(negedge clk);
                fb_valid = 1'b0;
                if (sc / 16 == 4) begin
                    chk({tag, ".solved_done"}, done, 1);
                    chk({tag, ".solved"}, solved, 1);
                    chk({tag, ".solved_fail"}, fail, 0);
                    ended = 1'b1;
                end else if (n == MAX_TRIES || exp_g == 255) begin
                    chk({tag, ".budget_done"}, done, 1);
                    chk({tag, ".budget_fail"}, fail, 1);
                    chk({tag, ".budget_solved"}, solved, 0);
                    ended = 1'b1;
                end else begin
                    chk({tag, ".running_done"}, done, 0);
                    hist_g.push_back(exp_g);
                    hist_s.push_back(sc);
                    exp_g = next_guess(exp_g);
                end
            end
        end
        chk({tag, ".tries_end"}, tries, n);
        chk({tag, ".busy_end"}, busy, 0);
    endtask

    initial begin
        int w;
        reset = 1'b1;
        start = 1'b0;
        guess_ack = 1'b0;
        fb_valid = 1'b0;
        fb_correct = 4'd0;
        fb_misplaced = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_idle("reset");

        play(8'h00, 1'b0, 0, 1'b0, "sec00");
        play(8'h1B, 1'b0, -1, 1'b0, "sec1b");
        play(8'h00, 1'b1, -1, 1'b0, "contra");
        play(8'h03, 1'b0, 5, 1'b1, "hold");

        // Abort a game in WAIT_FB with reset.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!guess_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_wfb.gv_before", guess_valid, 1);
        guess_ack = 1'b1;
        @(negedge clk);
        guess_ack = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("rst_wfb");
        play(8'h00, 1'b0, 0, 1'b0, "after_rst");

        play(8'h05, 1'b0, -1, 1'b0, "sec05");
        play(8'hFF, 1'b0, -1, 1'b0, "secff");
        for (int r = 0; r < 4; r++) begin
            play(int'($urandom_range(0, 255)), 1'b0, -1, 1'b0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
